// File: rtl/fmul_pipe.sv
// rtl/fmul_pipe.sv - pipelined IEEE-754 single-precision multiplier with pass-through tag
module fmul_pipe #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             stall,
    input  logic [31:0]      x1,
    input  logic [31:0]      x2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    output logic [31:0]      y,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    // S1: unpacked operands
    logic             s1_v_q;
    logic             s1_s_q;
    logic [7:0]       s1_e1_q, s1_e2_q;
    logic [23:0]      s1_m1_q, s1_m2_q;
    logic [TAG_W-1:0] s1_tag_q;

    // S2: partial products and operand-class flags
    logic             s2_v_q;
    logic             s2_s_q;
    logic             s2_zero_q, s2_inf_q;
    logic [7:0]       s2_e1_q, s2_e2_q;
    logic [35:0]      s2_pp_lo_q, s2_pp_hi_q;
    logic [TAG_W-1:0] s2_tag_q;
    logic             s2_zero_d, s2_inf_d;
    logic [35:0]      s2_pp_lo_d, s2_pp_hi_d;

    // S3: top 25 bits of the 48-bit product and biased exponent
    logic             s3_v_q;
    logic             s3_s_q;
    logic             s3_zero_q, s3_inf_q;
    logic [9:0]       s3_e_q;
    logic [24:0]      s3_p_q;
    logic [TAG_W-1:0] s3_tag_q;
    logic [9:0]       s3_e_d;
    logic [24:0]      s3_p_d;

    // S4: normalised mantissa and exponent
    logic             s4_v_q;
    logic             s4_s_q;
    logic             s4_zero_q, s4_inf_q;
    logic [9:0]       s4_ey_q;
    logic [22:0]      s4_my_q;
    logic [TAG_W-1:0] s4_tag_q;
    logic [9:0]       s4_ey_d;
    logic [22:0]      s4_my_d;

    // Output register
    logic             out_valid_q;
    logic [31:0]      y_q;
    logic [TAG_W-1:0] out_tag_q;
    logic [31:0]      y_d;

    // S1: capture sign, exponents and mantissas with the hidden bit restored
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v_q   <= 1'b0;
            s1_s_q   <= 1'b0;
            s1_e1_q  <= 8'd0;
            s1_e2_q  <= 8'd0;
            s1_m1_q  <= 24'd0;
            s1_m2_q  <= 24'd0;
            s1_tag_q <= '0;
        end else if (!stall) begin
            s1_v_q   <= in_valid;
            s1_s_q   <= x1[31] ^ x2[31];
            s1_e1_q  <= x1[30:23];
            s1_e2_q  <= x2[30:23];
            s1_m1_q  <= {1'b1, x1[22:0]};
            s1_m2_q  <= {1'b1, x2[22:0]};
            s1_tag_q <= in_tag;
        end
    end

    // S2 next state: split the 24x24 multiply into two 24x12 halves
    always_comb begin
        s2_pp_lo_d = 36'(s1_m1_q) * 36'(s1_m2_q[11:0]);
        s2_pp_hi_d = 36'(s1_m1_q) * 36'(s1_m2_q[23:12]);
        s2_zero_d  = (s1_e1_q == 8'd0) || (s1_e2_q == 8'd0);
        s2_inf_d   = (s1_e1_q == 8'hFF) || (s1_e2_q == 8'hFF);
    end

    // S2 registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_v_q     <= 1'b0;
            s2_s_q     <= 1'b0;
            s2_zero_q  <= 1'b0;
            s2_inf_q   <= 1'b0;
            s2_e1_q    <= 8'd0;
            s2_e2_q    <= 8'd0;
            s2_pp_lo_q <= 36'd0;
            s2_pp_hi_q <= 36'd0;
            s2_tag_q   <= '0;
        end else if (!stall) begin
            s2_v_q     <= s1_v_q;
            s2_s_q     <= s1_s_q;
            s2_zero_q  <= s2_zero_d;
            s2_inf_q   <= s2_inf_d;
            s2_e1_q    <= s1_e1_q;
            s2_e2_q    <= s1_e2_q;
            s2_pp_lo_q <= s2_pp_lo_d;
            s2_pp_hi_q <= s2_pp_hi_d;
            s2_tag_q   <= s1_tag_q;
        end
    end

    // S3 next state: combine halves; only P[47:23] matters after truncation
    always_comb begin
        s3_p_d = 25'((48'(s2_pp_lo_q) + {s2_pp_hi_q, 12'd0}) >> 23);
        s3_e_d = {2'b00, s2_e1_q} + {2'b00, s2_e2_q} - 10'd127;
    end

    // S3 registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s3_v_q    <= 1'b0;
            s3_s_q    <= 1'b0;
            s3_zero_q <= 1'b0;
            s3_inf_q  <= 1'b0;
            s3_e_q    <= 10'd0;
            s3_p_q    <= 25'd0;
            s3_tag_q  <= '0;
        end else if (!stall) begin
            s3_v_q    <= s2_v_q;
            s3_s_q    <= s2_s_q;
            s3_zero_q <= s2_zero_q;
            s3_inf_q  <= s2_inf_q;
            s3_e_q    <= s3_e_d;
            s3_p_q    <= s3_p_d;
            s3_tag_q  <= s2_tag_q;
        end
    end

    // S4 next state: normalise on the product carry bit, truncating the mantissa
    always_comb begin
        s4_my_d = s3_p_q[24] ? s3_p_q[23:1] : s3_p_q[22:0];
        s4_ey_d = s3_e_q + {9'd0, s3_p_q[24]};
    end

    // S4 registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s4_v_q    <= 1'b0;
            s4_s_q    <= 1'b0;
            s4_zero_q <= 1'b0;
            s4_inf_q  <= 1'b0;
            s4_ey_q   <= 10'd0;
            s4_my_q   <= 23'd0;
            s4_tag_q  <= '0;
        end else if (!stall) begin
            s4_v_q    <= s3_v_q;
            s4_s_q    <= s3_s_q;
            s4_zero_q <= s3_zero_q;
            s4_inf_q  <= s3_inf_q;
            s4_ey_q   <= s4_ey_d;
            s4_my_q   <= s4_my_d;
            s4_tag_q  <= s3_tag_q;
        end
    end

    // Exception selection in priority order: zero operand, inf/NaN operand, underflow, overflow
    always_comb begin
        y_d = {s4_s_q, s4_ey_q[7:0], s4_my_q};
        if (s4_zero_q) begin
            y_d = {s4_s_q, 31'd0};
        end else if (s4_inf_q) begin
            y_d = {s4_s_q, 8'hFF, 23'd0};
        end else if ($signed(s4_ey_q) <= 10'sd0) begin
            y_d = {s4_s_q, 31'd0};
        end else if ($signed(s4_ey_q) >= 10'sd255) begin
            y_d = {s4_s_q, 8'hFF, 23'd0};
        end
    end

    // Output register: held under stall so a presented result stays visible
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            y_q         <= 32'd0;
            out_tag_q   <= '0;
        end else if (!stall) begin
            out_valid_q <= s4_v_q;
            y_q         <= y_d;
            out_tag_q   <= s4_tag_q;
        end
    end

    assign out_valid = out_valid_q;
    assign y         = y_q;
    assign out_tag   = out_tag_q;
    assign busy      = s1_v_q | s2_v_q | s3_v_q | s4_v_q | out_valid_q;

endmodule

// File: tb/tb_fmul_pipe.sv
// tb/tb_fmul_pipe.sv - self-checking bench for fmul_pipe against a scoreboard reference
module tb_fmul_pipe;

    localparam int TAG_W = 5;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             stall;
    logic [31:0]      x1, x2;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic [31:0]      y;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0]      y;
        logic [TAG_W-1:0] tag;
        int               age;
    } op_t;

    op_t q[$];

    fmul_pipe #(.TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall),
        .x1(x1), .x2(x2), .in_tag(in_tag),
        .out_valid(out_valid), .y(y), .out_tag(out_tag), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        int          e1, e2, ey;
        logic [47:0] p;
        logic [22:0] m;
        s  = a[31] ^ b[31];
        e1 = int'(a[30:23]);
        e2 = int'(b[30:23]);
        if (e1 == 0 || e2 == 0) return {s, 31'd0};
        if (e1 == 255 || e2 == 255) return {s, 8'hFF, 23'd0};
        p  = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        ey = e1 + e2 - 127 + int'(p[47]);
        if (ey <= 0) return {s, 31'd0};
        if (ey >= 255) return {s, 8'hFF, 23'd0};
        m = p[47] ? p[46:24] : p[45:23];
        return {s, ey[7:0], m};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: present inputs, advance the reference on the edge, then compare
    task automatic cycle(input logic v, input logic st, input logic [31:0] a,
                         input logic [31:0] b, input logic [TAG_W-1:0] t);
        op_t e;
        logic exp_v;
        in_valid = v; stall = st; x1 = a; x2 = b; in_tag = t;
        @(posedge clk);
        if (!rst && !st) begin
            foreach (q[i]) q[i].age++;
            if (q.size() > 0 && q[0].age > 4) void'(q.pop_front());
            if (v) begin
                e.y = ref_mul(a, b); e.tag = t; e.age = 0;
                q.push_back(e);
            end
        end
        #1;
        exp_v = (q.size() > 0) && (q[0].age == 4);
        chk("out_valid", 32'(out_valid), 32'(exp_v));
        chk("busy", 32'(busy), 32'(q.size() > 0));
        if (exp_v) begin
            chk("y", y, q[0].y);
            chk("out_tag", 32'(out_tag), 32'(q[0].tag));
        end
    endtask

    task automatic single(input logic [31:0] a, input logic [31:0] b,
                          input logic [TAG_W-1:0] t, input logic [31:0] exp_y);
        cycle(1'b1, 1'b0, a, b, t);
        repeat (4) cycle(1'b0, 1'b0, 32'd0, 32'd0, '0);
        chk("directed_valid", 32'(out_valid), 32'd1);
        chk("directed_y", y, exp_y);
        chk("directed_tag", 32'(out_tag), 32'(t));
        cycle(1'b0, 1'b0, 32'd0, 32'd0, '0);
    endtask

    function automatic logic [31:0] rand_fp();
        logic [7:0] e;
        int r;
        r = int'($urandom_range(0, 19));
        if (r == 0) e = 8'd0;
        else if (r == 1) e = 8'hFF;
        else e = 8'($urandom_range(1, 254));
        return {1'($urandom), e, 23'($urandom)};
    endfunction

    initial begin
        rst = 1'b1; in_valid = 1'b0; stall = 1'b0; x1 = '0; x2 = '0; in_tag = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_y", y, 32'd0);
        chk("rst_out_tag", 32'(out_tag), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;

        // Directed values
        single(32'h40000000, 32'h40400000, 5'd3, 32'h40C00000);
        single(32'h3FC00000, 32'h3FC00000, 5'd7, 32'h40100000);
        single(32'hC0000000, 32'h40400000, 5'd9, 32'hC0C00000);
        single(32'h00800000, 32'h00800000, 5'd1, 32'h00000000);
        single(32'h7F000000, 32'h40000000, 5'd2, 32'h7F800000);
        single(32'h00000000, 32'h7F800000, 5'd4, 32'h00000000);

        // Back-to-back with a mid-stream stall, then a stall while results are presented
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, rand_fp(), rand_fp(), 5'(i));
        repeat (3) cycle(1'b1, 1'b1, rand_fp(), rand_fp(), 5'd31);
        for (int i = 3; i < 6; i++) cycle(1'b1, 1'b0, rand_fp(), rand_fp(), 5'(i));
        cycle(1'b0, 1'b0, 32'd0, 32'd0, '0);
        repeat (3) cycle(1'b0, 1'b1, 32'd0, 32'd0, '0);
        repeat (8) cycle(1'b0, 1'b0, 32'd0, 32'd0, '0);

        // Alternating issue pattern and busy drain
        for (int i = 0; i < 8; i++) cycle(1'(i % 2 == 0), 1'b0, rand_fp(), rand_fp(), 5'(10 + i));
        repeat (7) cycle(1'b0, 1'b0, 32'd0, 32'd0, '0);
        chk("drain_busy", 32'(busy), 32'd0);

        // Asynchronous reset with ops in flight
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, rand_fp(), rand_fp(), 5'(20 + i));
        #2 rst = 1'b1;
        q.delete();
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_y", y, 32'd0);
        repeat (2) cycle(1'b0, 1'b0, 32'd0, 32'd0, '0);
        rst = 1'b0;
        repeat (8) cycle(1'b0, 1'b0, 32'd0, 32'd0, '0);

        // Randomised traffic with random stalls and bubbles
        for (int i = 0; i < 10000; i++)
            cycle(1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 9) == 0),
                  rand_fp(), rand_fp(), 5'($urandom));
        repeat (8) cycle(1'b0, 1'b0, 32'd0, 32'd0, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
